// File: rtl/tdc_reg_access.sv
// tdc_reg_access
//   Turns one TDC register read/write command into a burst of SPI bytes for
//   the byte-level tdc_spi_master. The burst is a command byte followed by
//   1..3 data bytes, with chip select held low across it (spi_cs_end flags
//   the last byte). Read data comes back right-aligned.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_write           1 = write, 0 = read
//   cmd_addr[5:0]       register address
//   cmd_nbytes[1:0]     data bytes 1..3 (0 is rejected with rsp_err)
//   cmd_wdata[23:0]     write data, right-aligned, MSB byte sent first
//   rsp_valid           one-cycle completion pulse
//   rsp_err             illegal nbytes or per-byte timeout
//   rsp_rdata[23:0]     read data, right-aligned; 0 for writes
//   spi_start           one-cycle byte start to the SPI master
//   spi_data_in[7:0]    byte to send, stable until spi_new_data
//   spi_cs_end          set for the last byte of the burst
//   spi_busy            master busy (observed only)
//   spi_new_data        master byte-done pulse
//   spi_data_out[7:0]   byte received, valid with spi_new_data
module tdc_reg_access #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [5:0]  cmd_addr,
  input  logic [1:0]  cmd_nbytes,
  input  logic [23:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [23:0] rsp_rdata,
  output logic        spi_start,
  output logic [7:0]  spi_data_in,
  output logic        spi_cs_end,
  input  logic        spi_busy,
  input  logic        spi_new_data,
  input  logic [7:0]  spi_data_out
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;

  logic        wr_q;
  logic [5:0]  addr_q;
  logic [1:0]  nb_q;
  logic [23:0] wdata_q;
  logic [1:0]  byte_idx;
  logic [TW-1:0] to_cnt;
  logic        err_q;
  logic [23:0] rdata_q;

  logic        accept;
  logic        last_byte;
  logic        timeout;
  logic [7:0]  tx_byte;
  logic [1:0]  wsel;

  assign accept    = cmd_valid & cmd_ready;
  // Burst length is nbytes+1, so the last byte index equals nbytes.
  assign last_byte = (byte_idx == nb_q);
  assign timeout   = (state == S_WAIT) & ~spi_new_data &
                     (to_cnt == TW'(TIMEOUT_CYC - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (cmd_nbytes == 2'd0) ? S_DONE : S_LOAD;
      S_LOAD: state_nxt = S_WAIT;
      S_WAIT: begin
        if (spi_new_data) state_nxt = last_byte ? S_DONE : S_LOAD;
        else if (timeout) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs / byte selection
  always_comb begin
    // Ready stays low through the response pulse so a held cmd_valid is
    // only taken once the previous result has been presented.
    cmd_ready = (state == S_IDLE) & ~rsp_valid;
    wsel      = nb_q - byte_idx;
    tx_byte   = 8'h00;
    if (byte_idx == 2'd0)
      tx_byte = {(nb_q > 2'd1), wr_q, addr_q};
    else if (wr_q) begin
      case (wsel)
        2'd0:    tx_byte = wdata_q[7:0];
        2'd1:    tx_byte = wdata_q[15:8];
        default: tx_byte = wdata_q[23:16];
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q        <= 1'b0;
      addr_q      <= '0;
      nb_q        <= '0;
      wdata_q     <= '0;
      byte_idx    <= '0;
      to_cnt      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      spi_start   <= 1'b0;
      spi_data_in <= '0;
      spi_cs_end  <= 1'b0;
    end else begin
      spi_start <= (state == S_LOAD);
      rsp_valid <= (state == S_DONE);
      rsp_err   <= (state == S_DONE) & err_q;

      case (state)
        S_IDLE: begin
          if (accept) begin
            wr_q     <= cmd_write;
            addr_q   <= cmd_addr;
            nb_q     <= cmd_nbytes;
            wdata_q  <= cmd_wdata;
            byte_idx <= '0;
            to_cnt   <= '0;
            rdata_q  <= '0;
            err_q    <= (cmd_nbytes == 2'd0);
          end
        end
        S_LOAD: begin
          spi_data_in <= tx_byte;
          spi_cs_end  <= last_byte;
          to_cnt      <= to_cnt + 1'b1;
        end
        S_WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (spi_new_data) begin
            // Byte 0 is the command byte; what comes back with it is junk.
            if (!wr_q && byte_idx != 2'd0)
              rdata_q <= {rdata_q[15:0], spi_data_out};
            if (!last_byte) begin
              byte_idx <= byte_idx + 1'b1;
              // Counter is zero on entry to LOAD so the budget covers LOAD+WAIT.
              to_cnt   <= '0;
            end
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        S_DONE: rsp_rdata <= wr_q ? 24'h0 : rdata_q;
        default: ;
      endcase
    end
  end

  // The master must have finished the previous byte before the next launch.
  assert property (@(posedge clk) disable iff (rst) (state == S_LOAD) |-> !spi_busy);

endmodule

// File: tb/tb_tdc_reg_access.sv
module tb_tdc_reg_access;
  localparam int T = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [1:0]  cmd_nbytes;
  logic [23:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [23:0] rsp_rdata;
  logic        spi_start, spi_cs_end, spi_busy, spi_new_data;
  logic [7:0]  spi_data_in, spi_data_out;

  tdc_reg_access #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_nbytes(cmd_nbytes), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .spi_start(spi_start), .spi_data_in(spi_data_in), .spi_cs_end(spi_cs_end),
    .spi_busy(spi_busy), .spi_new_data(spi_new_data), .spi_data_out(spi_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  // Slave-side records for the current command
  int mosi_q[$], cse_q[$], st_q[$], nd_q[$], miso_q[$], fixed_q[$];
  bit slave_mute = 1'b0;
  int slave_dly  = -1;
  int sd, sb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SPI master stand-in: answer each start after a few cycles
  initial begin
    spi_new_data = 1'b0; spi_data_out = 8'h00; spi_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (spi_start) begin
        mosi_q.push_back(spi_data_in);
        cse_q.push_back(spi_cs_end);
        st_q.push_back(cyc);
        if (!slave_mute) begin
          spi_busy = 1'b1;
          sd = (slave_dly < 0) ? $urandom_range(0, 3) : slave_dly;
          repeat (sd) @(negedge clk);
          sb = (fixed_q.size() != 0) ? fixed_q.pop_front() : $urandom_range(0, 255);
          spi_data_out = sb[7:0];
          spi_new_data = 1'b1;
          nd_q.push_back(cyc);
          miso_q.push_back(sb);
          @(negedge clk);
          spi_new_data = 1'b0;
          spi_busy     = 1'b0;
          spi_data_out = 8'($urandom_range(0, 255));
        end
      end
    end
  end

  task automatic issue(input bit w, input logic [5:0] ad, input logic [1:0] nb,
                       input logic [23:0] wd, input bit hold, output int acc);
    int n = 0;
    cmd_write = w; cmd_addr = ad; cmd_nbytes = nb; cmd_wdata = wd; cmd_valid = 1'b1;
    while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("accept_tmo", 0, 1);
    acc = cyc;
    mosi_q.delete(); cse_q.delete(); st_q.delete(); nd_q.delete(); miso_q.delete();
    @(negedge clk);
    if (!hold) begin
      // Fields are free to change after acceptance
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom); cmd_addr = 6'($urandom);
      cmd_nbytes = 2'($urandom); cmd_wdata = 24'($urandom);
    end
  endtask

  // mode: 0 normal, 1 nbytes=0, 2 timeout
  task automatic check_rsp(input string nm, input bit w, input logic [5:0] ad,
                           input logic [1:0] nb, input logic [23:0] wd,
                           input int acc, input int mode, output int rc);
    int n = 0;
    int nbi, em;
    logic [31:0] exp_rd;
    nbi = nb;
    rc  = 0;
    while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
    if (!rsp_valid) begin chk({nm, "_rsp_tmo"}, 0, 1); return; end
    rc = cyc;
    chk({nm, "_err"}, rsp_err, (mode != 0));
    chk({nm, "_rdy_in_rsp"}, cmd_ready, 0);
    exp_rd = 0;
    if (mode == 0) begin
      chk({nm, "_nstart"}, mosi_q.size(), nbi + 1);
      if (mosi_q.size() == nbi + 1 && nd_q.size() == nbi + 1) begin
        for (int k = 0; k <= nbi; k++) begin
          if (k == 0) em = {24'h0, (nbi > 1), w, ad};
          else        em = w ? ((wd >> (8 * (nbi - k))) & 255) : 0;
          chk({nm, "_mosi"}, mosi_q[k], em);
          chk({nm, "_cs_end"}, cse_q[k], (k == nbi));
          chk({nm, "_start_lat"}, st_q[k], (k == 0) ? acc + 2 : nd_q[k-1] + 2);
        end
        chk({nm, "_rsp_lat"}, rc, nd_q[nbi] + 2);
        if (!w) for (int k = 1; k <= nbi; k++) exp_rd = exp_rd * 256 + miso_q[k];
        chk({nm, "_rdata"}, rsp_rdata, exp_rd);
      end
    end else if (mode == 1) begin
      chk({nm, "_nstart"}, mosi_q.size(), 0);
      chk({nm, "_lat_le3"}, (rc - acc) <= 3, 1);
    end else begin
      chk({nm, "_nstart"}, mosi_q.size(), 1);
      if (st_q.size() != 0) chk({nm, "_tmo_lat"}, rc, st_q[0] + T);
      chk({nm, "_cs_end_kept"}, spi_cs_end, 0);
    end
    @(negedge clk);
    chk({nm, "_pulse"}, rsp_valid, 0);
    chk({nm, "_rdy_after"}, cmd_ready, 1);
    if (mode == 0) chk({nm, "_rdata_hold"}, rsp_rdata, exp_rd);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ready"}, cmd_ready, 1);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_rsp_err"}, rsp_err, 0);
    chk({nm, "_rdata"}, rsp_rdata, 0);
    chk({nm, "_start"}, spi_start, 0);
    chk({nm, "_din"}, spi_data_in, 0);
    chk({nm, "_cs_end"}, spi_cs_end, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rc, rc1, pulses;
    bit w;
    logic [5:0] ad;
    logic [1:0] nb;
    logic [23:0] wd;

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_nbytes = '0; cmd_wdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: single-byte write
    issue(1'b1, 6'h00, 2'd1, 24'h000003, 1'b0, acc);
    check_rsp("wr1", 1'b1, 6'h00, 2'd1, 24'h000003, acc, 0, rc);

    // 2: 3-byte read with known slave data
    fixed_q = '{8'hEE, 8'h12, 8'h34, 8'h56};
    issue(1'b0, 6'h10, 2'd3, 24'h0, 1'b0, acc);
    check_rsp("rd3", 1'b0, 6'h10, 2'd3, 24'h0, acc, 0, rc);
    chk("rd3_value", rsp_rdata, 24'h123456);

    // 3: illegal length
    issue(1'b1, 6'h05, 2'd0, 24'hABCDEF, 1'b0, acc);
    check_rsp("nb0", 1'b1, 6'h05, 2'd0, 24'hABCDEF, acc, 1, rc);

    // 4: slave never answers
    slave_mute = 1'b1;
    issue(1'b0, 6'h22, 2'd2, 24'h0, 1'b0, acc);
    check_rsp("tmo", 1'b0, 6'h22, 2'd2, 24'h0, acc, 2, rc);
    slave_mute = 1'b0;
    repeat (2) @(negedge clk);

    // 5: cmd_valid held across two commands
    fixed_q = '{8'h3C, 8'hA5};
    issue(1'b0, 6'h01, 2'd1, 24'h0, 1'b1, acc);
    cmd_write = 1'b1; cmd_addr = 6'h05; cmd_nbytes = 2'd2; cmd_wdata = 24'h00BEEF;
    check_rsp("b2b_rd", 1'b0, 6'h01, 2'd1, 24'h0, acc, 0, rc1);
    chk("b2b_rd_value", rsp_rdata, 24'h0000A5);
    issue(1'b1, 6'h05, 2'd2, 24'h00BEEF, 1'b0, acc);
    chk("b2b_accept_after_rsp", acc, rc1 + 1);
    check_rsp("b2b_wr", 1'b1, 6'h05, 2'd2, 24'h00BEEF, acc, 0, rc);

    // 6: reset during the second byte of a 3-byte write
    slave_dly = 5;
    issue(1'b1, 6'h2A, 2'd3, 24'h112233, 1'b0, acc);
    begin
      int n = 0;
      while (st_q.size() < 2 && n < 200) begin @(negedge clk); n++; end
      if (st_q.size() < 2) chk("rst_mid_second_start", st_q.size(), 2);
    end
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("rst_mid");
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin @(negedge clk); if (rsp_valid) pulses++; end
    chk("rst_mid_no_rsp", pulses, 0);
    slave_dly = -1;
    issue(1'b0, 6'h07, 2'd2, 24'h0, 1'b0, acc);
    check_rsp("post_rst", 1'b0, 6'h07, 2'd2, 24'h0, acc, 0, rc);

    // Random commands
    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom);
      ad = 6'($urandom);
      nb = 2'($urandom_range(0, 3));
      wd = 24'($urandom);
      issue(w, ad, nb, wd, 1'b0, acc);
      check_rsp("rand", w, ad, nb, wd, acc, (nb == 2'd0) ? 1 : 0, rc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
